// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared state encoding and sizing helper for the bit-serial adder.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width, never below one bit so degenerate widths stay legal.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fa_cell
//  Purpose  : Combinational 1-bit full adder driven by the serial sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder, LSB first, one bit per clock through a
//             single full-adder cell; valid/ready on both sides.
//             Optional signed overflow output: define SERIAL_ADDER_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_cout
);

   localparam int               C_CNT_W = cnt_width(WIDTH);
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);
   localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [C_CNT_W-1:0] r_cnt;
   logic               w_accept;
   logic               w_last;
   logic               w_cell_sum;
   logic               w_cell_cout;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_state == RUN) && (r_cnt == C_LAST);

   fa_cell u_fa_cell (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .sum  (w_cell_sum),
      .cout (w_cell_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sr  <= in_a;
         r_b_sr  <= in_b;
         r_carry <= in_cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_sum   <= {w_cell_sum, r_sum[WIDTH-1:1]};
         r_carry <= w_cell_cout;
         r_a_sr  <= r_a_sr >> 1;
         r_b_sr  <= r_b_sr >> 1;
         r_cnt   <= r_cnt + C_ONE;
         if (w_last) begin
            r_cout <= w_cell_cout;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_cmsb;

   // Carry entering the MSB is the cell's carry-in on the final bit.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_cmsb <= 1'b0;
      end else if (w_last) begin
         r_cmsb <= r_carry;
      end
   end

   assign out_ovf = r_cmsb ^ r_cout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             areset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             out_ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
`ifdef SERIAL_ADDER_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out_cout  (out_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      int         stall;
      logic [7:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Returns after result is taken; caller is 1 time unit past a rising edge.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input int stall, input logic [7:0] es, input logic ec,
                         input logic eo, input string tag);
      int n;
      wait_ready(tag);
      out_ready = (stall == 0);
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(WIDTH));
      chk({tag, " sum"}, 32'(out_sum), 32'(es));
      chk({tag, " cout"}, 32'(out_cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, 32'(out_ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: undefined overflow expectation in %s", tag);
`endif
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         chk({tag, " hold"}, {21'd0, out_valid, in_ready, out_cout, out_sum},
             {21'd0, 1'b1, 1'b0, ec, es});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   vec_t vecs [8];

   initial begin
      logic [8:0] full;
      logic [7:0] ra, rb, rs;
      logic       rc, ro;
      logic [7:0] b2b_a [3];
      logic [7:0] b2b_b [3];
      logic       b2b_c [3];
      logic [7:0] b2b_s [3];
      logic       b2b_o [3];
      int         n;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0};
      vecs[6] = '{8'h3C, 8'hC3, 1'b1, 5, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 2, 8'h00, 1'b0, 1'b0};

      areset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset state", {21'd0, in_ready, out_valid, out_cout, out_sum},
          {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk);
      areset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      end

      // Reset in the middle of a run discards the partial result at once.
      wait_ready("rst");
      in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      areset = 1'b1;
      #1;
      chk("midrun reset", {21'd0, in_ready, out_valid, out_cout, out_sum},
          {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk);
      areset = 1'b0;
      @(posedge clk); #1;
      run_op(8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0, "post reset");

      // Back-to-back with in_valid held high across all three operand sets.
      b2b_a = '{8'h12, 8'hF0, 8'h55};
      b2b_b = '{8'h34, 8'h20, 8'hAA};
      b2b_c = '{1'b0,  1'b1,  1'b1};
      b2b_s = '{8'h46, 8'h11, 8'h00};
      b2b_o = '{1'b0,  1'b1,  1'b1};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = b2b_a[i]; in_b = b2b_b[i]; in_cin = b2b_c[i];
         wait_ready($sformatf("b2b%0d", i));
         @(posedge clk); #1;
         n = 0;
         while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("b2b%0d latency", i), 32'(n), 32'(WIDTH));
         chk($sformatf("b2b%0d result", i), {23'd0, out_cout, out_sum}, {23'd0, b2b_o[i], b2b_s[i]});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         rs = full[7:0];
         ro = (ra[7] == rb[7]) && (rs[7] != ra[7]);
         run_op(ra, rb, rc, int'($urandom_range(0, 3)), rs, full[8], ro, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
